// File: rtl/riscv_rf_pkg.sv
// Shared constants and write-port arbitration helper for the multi-port register file.
package riscv_rf_pkg;
    localparam int          XLEN_DEF     = 64;
    localparam int          NREG_DEF     = 32;
    localparam int          SP_IDX       = 2;
    localparam logic [63:0] SP_RESET_DEF = 64'h3ffffffb40;

    // Upper bounds for the arbitration helper; instances zero-extend into these.
    localparam int MAX_WR = 8;
    localparam int MAX_AW = 8;

    typedef logic [MAX_WR-1:0]        wren_vec_t;
    typedef logic [MAX_WR*MAX_AW-1:0] wraddr_vec_t;
    typedef logic [MAX_AW-1:0]        addr_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] port;
    } wr_sel_t;

    // Finds the highest-index enabled write port targeting addr (x0 never hits).
    function automatic wr_sel_t wr_select(input wren_vec_t   wren,
                                          input wraddr_vec_t wraddr,
                                          input int          nwr,
                                          input int          aw,
                                          input addr_t       addr);
        wr_sel_t sel;
        addr_t   mask;
        addr_t   a;
        sel  = '0;
        mask = addr_t'((1 << aw) - 1);
        for (int i = 0; i < MAX_WR; i++) begin
            a = addr_t'(wraddr >> (i * aw)) & mask;
            if (i < nwr && wren[i] && addr != '0 && a == addr) begin
                sel.hit  = 1'b1;
                sel.port = 3'(i);
            end
        end
        return sel;
    endfunction
endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Per-register busy bits: flush beats alloc, alloc beats writeback clear.
module riscv_rf_scoreboard
    import riscv_rf_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NWR-1:0]    wren_i,
    input  logic [NWR*AW-1:0] wraddr_i,
    input  logic              alloc_en_i,
    input  logic [AW-1:0]     alloc_addr_i,
    input  logic              flush_i,
    output logic [NREG-1:0]   busy_o,
    output logic              busy_any_o
);
    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_d;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        clr_mask = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wren_i[w] && wraddr_i[w*AW +: AW] != '0) begin
                clr_mask[wraddr_i[w*AW +: AW]] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (alloc_en_i && alloc_addr_i == AW'(r)) begin
                busy_d[r] = 1'b1;
            end else if (clr_mask[r]) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o     = {busy_q, 1'b0};
    assign busy_any_o = |busy_q;
endmodule

// File: rtl/riscv_rf_mp.sv
// Multi-port integer register file with optional write-to-read bypass and busy scoreboard.
module riscv_rf_mp
    import riscv_rf_pkg::*;
#(
    parameter int          XLEN     = XLEN_DEF,
    parameter int          NREG     = NREG_DEF,
    parameter int          NRD      = 2,
    parameter int          NWR      = 2,
    parameter logic [63:0] SP_RESET = SP_RESET_DEF,
    parameter bit          BYPASS   = 1'b1,
    localparam int         AW       = $clog2(NREG)
) (
    input  logic                i_riscv_rf_clk,
    input  logic                i_riscv_rf_rst_n,
    input  logic [NRD*AW-1:0]   i_riscv_rf_rdaddr,
    output logic [NRD*XLEN-1:0] o_riscv_rf_rddata,
    output logic [NRD-1:0]      o_riscv_rf_rdbusy,
    input  logic [NWR-1:0]      i_riscv_rf_wren,
    input  logic [NWR*AW-1:0]   i_riscv_rf_wraddr,
    input  logic [NWR*XLEN-1:0] i_riscv_rf_wrdata,
    input  logic                i_riscv_rf_alloc_en,
    input  logic [AW-1:0]       i_riscv_rf_alloc_addr,
    input  logic                i_riscv_rf_flush,
    output logic                o_riscv_rf_busy_any
);
    localparam logic [XLEN-1:0] SP_RST = XLEN'(SP_RESET);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];
    logic [NREG-1:0] busy_vec;
    wren_vec_t       wren_ext;
    wraddr_vec_t     wraddr_ext;

    assign wren_ext   = wren_vec_t'(i_riscv_rf_wren);
    assign wraddr_ext = wraddr_vec_t'(i_riscv_rf_wraddr);

    always_comb begin
        wr_sel_t wsel;
        wsel = '0;
        for (int r = 1; r < NREG; r++) begin
            wsel      = wr_select(wren_ext, wraddr_ext, NWR, AW, addr_t'(r));
            regs_d[r] = regs_q[r];
            if (wsel.hit) begin
                regs_d[r] = i_riscv_rf_wrdata[int'(wsel.port)*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge i_riscv_rf_clk or negedge i_riscv_rf_rst_n) begin
        if (!i_riscv_rf_rst_n) begin
            for (int r = 1; r < NREG; r++) begin
                regs_q[r] <= (r == SP_IDX) ? SP_RST : '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // A bypassed read also reports not-busy: the producer's value is on the write bus now.
    always_comb begin
        wr_sel_t         rsel;
        logic [AW-1:0]   ra;
        rsel              = '0;
        ra                = '0;
        o_riscv_rf_rddata = '0;
        o_riscv_rf_rdbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            ra   = i_riscv_rf_rdaddr[k*AW +: AW];
            rsel = wr_select(wren_ext, wraddr_ext, NWR, AW, addr_t'(ra));
            if (ra != '0) begin
                if (BYPASS && rsel.hit) begin
                    o_riscv_rf_rddata[k*XLEN +: XLEN] =
                        i_riscv_rf_wrdata[int'(rsel.port)*XLEN +: XLEN];
                end else begin
                    o_riscv_rf_rddata[k*XLEN +: XLEN] = regs_q[ra];
                    o_riscv_rf_rdbusy[k]              = busy_vec[ra];
                end
            end
        end
    end

    riscv_rf_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW)
    ) u_scoreboard (
        .clk_i        (i_riscv_rf_clk),
        .rst_ni       (i_riscv_rf_rst_n),
        .wren_i       (i_riscv_rf_wren),
        .wraddr_i     (i_riscv_rf_wraddr),
        .alloc_en_i   (i_riscv_rf_alloc_en),
        .alloc_addr_i (i_riscv_rf_alloc_addr),
        .flush_i      (i_riscv_rf_flush),
        .busy_o       (busy_vec),
        .busy_any_o   (o_riscv_rf_busy_any)
    );
endmodule

// File: doc/riscv_rf_mp.md
Name: riscv_rf_mp

Overview:
Parametrised multi-port integer register file, the successor of the single-write, two-read RV64 register file.
- Configurable XLEN, register count, read-port count and write-port count.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard (allocate on issue, release on writeback) so the issue stage can detect RAW hazards.
- Sits between decode/issue (reads, allocate) and writeback (writes) of the pipeline.

Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of architectural registers (power of 2); AW = $clog2(NREG).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- SP_RESET, 64'h3ffffffb40, reset value of x2 (stack pointer), truncated to XLEN.
- BYPASS, 1, 1 = reads see same-cycle writes; 0 = reads see registered contents only.

Ports:
- i_riscv_rf_clk, input, 1, clock; all state updates on rising edge.
- i_riscv_rf_rst_n, input, 1, reset; one clock, reset asynchronous and active-low.
- i_riscv_rf_rdaddr, input, NRD*AW, read addresses, packed, port k at [k*AW +: AW].
- o_riscv_rf_rddata, output, NRD*XLEN, read data, packed per port.
- o_riscv_rf_rdbusy, output, NRD, busy flag of the addressed register per read port.
- i_riscv_rf_wren, input, NWR, write enables.
- i_riscv_rf_wraddr, input, NWR*AW, write addresses.
- i_riscv_rf_wrdata, input, NWR*XLEN, write data.
- i_riscv_rf_alloc_en, input, 1, mark destination busy (instruction issued).
- i_riscv_rf_alloc_addr, input, AW, destination to mark busy.
- i_riscv_rf_flush, input, 1, clear all busy bits (pipeline flush).
- o_riscv_rf_busy_any, output, 1, OR of all busy bits (registered state).

Behaviour:
- Reset (async assert, sync-to-clock deassert handled upstream):
  - All registers are 0 except x2 = SP_RESET.
  - All busy bits are 0; o_riscv_rf_busy_any = 0.
  - Read outputs reflect the reset contents combinationally.
- x0:
  - Reads always return 0 and busy 0.
  - Writes and allocates to x0 are ignored; no storage or busy bit is kept for x0.
- Write:
  - On a rising edge, each port with wren=1 and addr≠0 updates its register.
  - Several ports writing the same address in one cycle: the highest-index port wins.
- Read (combinational, zero latency):
  - BYPASS=0: data = registered content.
  - BYPASS=1: if any enabled write port targets the read address (≠0), data = that port's wrdata, highest-index port winning. Otherwise data = registered content.
- Busy scoreboard, updated on the rising edge, priority highest first:
  1. flush=1 clears every busy bit; a same-cycle alloc is ignored.
  2. alloc_en=1 with alloc_addr≠0 sets busy[alloc_addr]. This wins over a same-cycle write to that address, because the new producer owns the register.
  3. Any enabled write to address a (≠0) clears busy[a].
  - Writes update data even when busy=0 or flush=1.
- rdbusy[k]:
  - = busy[addr_k], 0 for x0.
  - BYPASS=1: forced 0 when a same-cycle enabled write targets addr_k, because the data is valid via bypass.
  - Not affected by a same-cycle alloc; the alloc is visible from the next cycle.
- o_riscv_rf_busy_any: OR of registered busy bits; no bypass masking.
- Reset asserted mid-operation: contents and busy bits return to reset values immediately; in-flight writes that cycle are lost.
- Read ports are independent; any number may address the same register.

Decomposition:
- Package riscv_rf_pkg holds:
  - Default constants XLEN_DEF, NREG_DEF, SP_IDX = 2, SP_RESET_DEF.
  - Function wr_select(): returns hit flag and winning port index for an address, used by both write and bypass logic.
- Sub-module riscv_rf_scoreboard: the busy-bit array with alloc/clear/flush priority and busy_any. The top level holds storage, write decode and read/bypass muxes.

Test Plan:
- Reset, then read x0, x1, x2 -> 0, 0, 64'h3ffffffb40; all rdbusy = 0, busy_any = 0.
- Write port0 x5 = 0xAAAA and port1 x5 = 0x5555 in the same cycle; next cycle read x5 -> 0x5555. Write x0 = 0xFFFF -> x0 still reads 0.
- BYPASS=1: write x7 = 0x1234 and read x7 in the same cycle -> 0x1234 that cycle. With BYPASS=0 the same stimulus -> old value that cycle, 0x1234 next cycle.
- Allocate x3 -> next cycle rdbusy = 1 and busy_any = 1. Write x3 = 0x99 -> same cycle rdbusy = 0 (BYPASS=1); next cycle busy bit clear, busy_any = 0.
- Alloc x4 and write x4 in the same cycle -> x4 data updated, busy[x4] = 1 afterwards. Alloc x6 with flush in the same cycle -> busy[x6] = 0, busy_any = 0.
- Assert rst_n low between clock edges after writing x9 = 0x77 and allocating x9 -> x9 reads 0 and rdbusy = 0 immediately, before the next edge.
